cp0_irq_ctrl: RTL

- Coprocessor-0 successor with NUM_IRQ prioritised, maskable external interrupt lines plus an internal timer-compare interrupt.
- Provides STATUS/CAUSE registers, an in-service lock that clears on ERET, and a readable/writable cycle timer with a compare register.
- Reads happen in the ID stage, writes in the EXE stage, and the exception check in the MEM stage.
- Drives the pipeline's forced-jump (jump_en/jump_addr) path.

---
 rtl/mips_define.sv | 23 ++
 rtl/cp0_prio_enc.sv | 19 +
 rtl/cp0_irq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_define.sv
// Shared MIPS-pipeline definitions: CP0 operation encodings, CP0 register
// addresses and STATUS/CAUSE field positions.
package mips_define;

    typedef enum logic [1:0] {
        EXE_CP_NONE  = 2'd0,
        EXE_CP_STORE = 2'd1,
        EXE_CP0_ERET = 2'd2
    } cp0_oper_e;

    localparam logic [4:0] CP0_TCR    = 5'd9;
    localparam logic [4:0] CP0_TCMP   = 5'd11;
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPCR   = 5'd14;
    localparam logic [4:0] CP0_EHBR   = 5'd15;

    localparam int STATUS_IE_BIT  = 0;
    localparam int IRQ_FIELD_LSB  = 8;
    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_CODE_W   = 5;

endpackage

// File: rtl/cp0_prio_enc.sv
// Lowest-index-wins priority encoder for the CP0 interrupt sources.
module cp0_prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [4:0]   index
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = 5'(i);
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: STATUS/CAUSE/EPCR/EHBR, cycle timer with compare,
// in-service lock and forced-jump generation. Optional macro: CP0_VECTORED_IRQ_EN.
module cp0_irq_ctrl
    import mips_define::*;
#(
    parameter int NUM_IRQ   = 4,
    parameter int DATA_W    = 32,
    parameter int VEC_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        oper,
    input  logic [4:0]        addr_r,
    output logic [DATA_W-1:0] data_r,
    input  logic [4:0]        addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              ir_en,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [DATA_W-1:0] ret_addr,
    output logic              jump_en,
    output logic [DATA_W-1:0] jump_addr,
    output logic              in_service
);

    localparam int MSB = IRQ_FIELD_LSB + NUM_IRQ;

`ifdef CP0_VECTORED_IRQ_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    logic              ie;
    logic [NUM_IRQ:0]  mask;
    logic [NUM_IRQ:0]  pend;
    logic [4:0]        code;
    logic [DATA_W-1:0] epcr, ehbr, tcr, tcmp;

    logic              is_store, is_eret;
    logic              wr_status, wr_cause, wr_epcr, wr_ehbr, wr_tcr, wr_tcmp;
    logic              timer_hit, req_valid, take;
    logic [NUM_IRQ:0]  req, pend_set, pend_clr;
    logic [4:0]        irq_idx;
    logic [DATA_W-1:0] vec_off;

    assign is_store  = (oper == EXE_CP_STORE);
    assign is_eret   = (oper == EXE_CP0_ERET);
    assign wr_status = is_store && (addr_w == CP0_STATUS);
    assign wr_cause  = is_store && (addr_w == CP0_CAUSE);
    assign wr_epcr   = is_store && (addr_w == CP0_EPCR);
    assign wr_ehbr   = is_store && (addr_w == CP0_EHBR);
    assign wr_tcr    = is_store && (addr_w == CP0_TCR);
    assign wr_tcmp   = is_store && (addr_w == CP0_TCMP);

    assign timer_hit = (tcr == tcmp) && (tcmp != '0);
    assign req       = pend & mask;

    cp0_prio_enc #(.N(NUM_IRQ + 1)) u_prio (
        .req   (req),
        .valid (req_valid),
        .index (irq_idx)
    );

    assign take    = ir_en && ie && req_valid && !in_service && !is_eret;
    assign vec_off = VECTORED ? (DATA_W'(irq_idx) << VEC_SHIFT) : '0;

    // New requests are OR-ed in after the clear so a same-cycle set survives.
    assign pend_set = {timer_hit, ir_in};
    assign pend_clr = (wr_cause ? data_w[MSB:IRQ_FIELD_LSB] : '0)
                    | (wr_tcmp  ? {1'b1, {NUM_IRQ{1'b0}}}  : '0);

    always_comb begin
        jump_en   = 1'b0;
        jump_addr = '0;
        if (!rst) begin
            if (is_eret) begin
                jump_en   = 1'b1;
                jump_addr = epcr;
            end else if (take) begin
                jump_en   = 1'b1;
                jump_addr = ehbr + vec_off;
            end
        end
    end

    always_comb begin
        data_r = '0;
        if (!rst) begin
            case (addr_r)
                CP0_STATUS: begin
                    data_r[STATUS_IE_BIT]       = ie;
                    data_r[MSB:IRQ_FIELD_LSB]   = mask;
                end
                CP0_CAUSE: begin
                    data_r[MSB:IRQ_FIELD_LSB]   = pend;
                    data_r[CAUSE_CODE_LSB +: CAUSE_CODE_W] = code;
                end
                CP0_EPCR: data_r = epcr;
                CP0_EHBR: data_r = ehbr;
                CP0_TCR:  data_r = tcr;
                CP0_TCMP: data_r = tcmp;
                default:  data_r = '0;
            endcase
        end
    end

    // A take owns EPCR this cycle; MTC0 to other registers still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie         <= 1'b0;
            mask       <= '0;
            pend       <= '0;
            code       <= '0;
            epcr       <= '0;
            ehbr       <= '0;
            tcr        <= '0;
            tcmp       <= '0;
            in_service <= 1'b0;
        end else begin
            tcr  <= wr_tcr ? data_w : tcr + DATA_W'(1);
            pend <= (pend & ~pend_clr) | pend_set;
            if (wr_status) begin
                ie   <= data_w[STATUS_IE_BIT];
                mask <= data_w[MSB:IRQ_FIELD_LSB];
            end
            if (wr_ehbr) ehbr <= data_w;
            if (wr_tcmp) tcmp <= data_w;
            if (take) begin
                epcr       <= ret_addr;
                code       <= irq_idx;
                in_service <= 1'b1;
            end else begin
                if (wr_epcr) epcr <= data_w;
                if (is_eret) in_service <= 1'b0;
            end
        end
    end

endmodule
